// File: rtl/ysyx_24110015_axi_rd_slave.sv
// ysyx_24110015_axi_rd_slave: AXI4 read responder with programmable latency/jitter over a side-loaded word memory
module ysyx_24110015_axi_rd_slave #(
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2,
    parameter int          JITTER  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arvalid,
    output logic                       arready,
    input  logic [31:0]                araddr,
    input  logic [3:0]                 arid,
    input  logic [7:0]                 arlen,
    input  logic [2:0]                 arsize,
    input  logic [1:0]                 arburst,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [31:0]                rdata,
    output logic [1:0]                 rresp,
    output logic                       rlast,
    output logic [3:0]                 rid,
    input  logic                       ld_en,
    input  logic [$clog2(DEPTH)-1:0]   ld_addr,
    input  logic [31:0]                ld_data
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, DELAY, DATA} state_t;

    state_t      state, state_n;
    logic [31:0] addr, off;
    logic [3:0]  id;
    logic [7:0]  len, beat, lfsr;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [15:0] cnt, cnt_load;
    logic        ar_hs, bad_req, in_range;
    logic [31:0] mem [DEPTH];

    assign arready  = (state == IDLE) && !rst;
    assign ar_hs    = arvalid && arready;
    assign rvalid   = state == DATA;
    assign cnt_load = 16'(LATENCY) + ((JITTER != 0) ? {14'd0, lfsr[1:0]} : 16'd0);
    assign off      = addr - BASE;
    assign in_range = (off >> (AW + 2)) == 32'd0;
    assign bad_req  = (size != 3'b010) || burst[1];
    // responses are decoded from the live beat address so INCR bursts can cross the top of memory
    assign rresp    = !rvalid ? 2'b00 : bad_req ? 2'b10 : !in_range ? 2'b11 : 2'b00;
    assign rdata    = (rvalid && !bad_req && in_range) ? mem[off[AW+1:2]] : 32'd0;
    assign rlast    = rvalid && (beat == len);
    assign rid      = rvalid ? id : 4'd0;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (ar_hs) state_n = (cnt_load != 16'd0) ? DELAY : DATA;
            DELAY:   if (cnt == 16'd1) state_n = DATA;
            DATA:    if (rready && rlast) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            addr  <= '0;
            id    <= '0;
            len   <= '0;
            size  <= '0;
            burst <= '0;
            beat  <= '0;
            cnt   <= '0;
            lfsr  <= 8'hA5;
        end else begin
            state <= state_n;
            lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (ar_hs) begin
                addr  <= araddr;
                id    <= arid;
                len   <= arlen;
                size  <= arsize;
                burst <= arburst;
                beat  <= '0;
                cnt   <= cnt_load;
            end else if (state == DELAY) begin
                cnt <= cnt - 16'd1;
            end
            if (rvalid && rready) begin
                beat <= beat + 8'd1;
                if (burst == 2'b01) addr <= addr + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
    end
endmodule

// File: tb/tb_ysyx_24110015_axi_rd_slave.sv
// tb_ysyx_24110015_axi_rd_slave: randomized checks of the AXI read responder against a memory scoreboard
module tb_ysyx_24110015_axi_rd_slave;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int DEPTH = 1024;

    logic        clk = 0, rst = 1;
    logic        arvalid = 0, arvalid_j = 0, rready = 1, ld_en = 0;
    logic [31:0] araddr = 0, ld_data = 0;
    logic [3:0]  arid = 0;
    logic [7:0]  arlen = 0;
    logic [2:0]  arsize = 3'b010;
    logic [1:0]  arburst = 0;
    logic [9:0]  ld_addr = 0;
    logic        arready, rvalid, rlast, arready_j, rvalid_j, rlast_j;
    logic [31:0] rdata, rdata_j;
    logic [1:0]  rresp, rresp_j;
    logic [3:0]  rid, rid_j;
    logic        use_j = 0;
    logic        s_arready, s_rvalid, s_rlast;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic [3:0]  s_rid;
    logic [31:0] model_mem [DEPTH];
    int          total = 0, bad = 0, hs_cnt = 0;

    always #5 clk = ~clk;

    ysyx_24110015_axi_rd_slave #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(2), .JITTER(0)) dut (
        .clk(clk), .rst(rst), .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst), .rvalid(rvalid), .rready(rready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data));

    ysyx_24110015_axi_rd_slave #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(2), .JITTER(1)) dut_j (
        .clk(clk), .rst(rst), .arvalid(arvalid_j), .arready(arready_j), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst), .rvalid(rvalid_j), .rready(rready),
        .rdata(rdata_j), .rresp(rresp_j), .rlast(rlast_j), .rid(rid_j), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data));

    assign s_arready = use_j ? arready_j : arready;
    assign s_rvalid  = use_j ? rvalid_j : rvalid;
    assign s_rlast   = use_j ? rlast_j : rlast;
    assign s_rdata   = use_j ? rdata_j : rdata;
    assign s_rresp   = use_j ? rresp_j : rresp;
    assign s_rid     = use_j ? rid_j : rid;

    always @(posedge clk) if (rvalid && rready) hs_cnt++;

    function automatic logic [33:0] exp_beat(input logic [31:0] a, input logic [2:0] sz,
                                             input logic [1:0] bt, input int i);
        logic [31:0] ba, o;
        ba = (bt == 2'b00) ? a : a + 32'(4 * i);
        o  = ba - BASE;
        if (sz != 3'b010 || bt[1]) return {2'b10, 32'd0};
        if (o >= 32'(4 * DEPTH)) return {2'b11, 32'd0};
        return {2'b00, model_mem[o[11:2]]};
    endfunction

    task automatic load(input int idx, input logic [31:0] d);
        ld_en = 1; ld_addr = 10'(idx); ld_data = d;
        @(posedge clk); #1;
        ld_en = 0;
        model_mem[idx] = d;
    endtask

    // mode: 0 rready held high, 1 pattern 1,0,0,1, 2 random
    task automatic run_burst(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                             input logic [1:0] bt, input logic [3:0] id, input int mode, output int lat);
        int cyc, beat, k;
        logic [33:0] e;
        logic [3:0] pat;
        logic rd;
        pat = 4'b1001;
        cyc = 0;
        rready = 1;
        while (!s_arready && cyc < 20) begin @(posedge clk); #1; cyc++; end
        total++;
        if (!s_arready) begin bad++; $display("FAIL ar_wait arready=%b required=1", s_arready); end
        if (use_j) arvalid_j = 1; else arvalid = 1;
        araddr = a; arlen = len; arsize = sz; arburst = bt; arid = id;
        @(posedge clk); #1;
        arvalid = 0; arvalid_j = 0;
        araddr = $urandom; arid = 4'($urandom);
        lat = 0;
        while (!s_rvalid && lat < 20) begin @(posedge clk); #1; lat++; end
        beat = 0; k = 0;
        while (beat <= int'(len) && k < 400) begin
            rready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[k % 4] : 1'($urandom);
            e = exp_beat(a, sz, bt, beat);
            total++;
            if ({s_rvalid, s_rlast, s_rid, s_rresp, s_rdata} !== {1'b1, beat == int'(len), id, e})
                begin
                bad++;
                $display("FAIL beat%0d addr=%h got v=%b last=%b id=%h resp=%b data=%h required last=%b id=%h resp=%b data=%h",
                         beat, a, s_rvalid, s_rlast, s_rid, s_rresp, s_rdata, beat == int'(len), id, e[33:32], e[31:0]);
            end
            rd = rready;
            @(posedge clk); #1;
            if (rd) beat++;
            k++;
        end
        rready = 1;
        total++;
        if (s_rvalid !== 1'b0 || s_arready !== 1'b1 || k >= 400) begin
            bad++;
            $display("FAIL post_burst rvalid=%b arready=%b required rvalid=0 arready=1", s_rvalid, s_arready);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({arready, rvalid, rlast, rresp, rdata, rid, arready_j, rvalid_j} !== '0) begin
            bad++;
            $display("FAIL reset arready=%b rvalid=%b rlast=%b rresp=%b rdata=%h rid=%h required all 0",
                     arready, rvalid, rlast, rresp, rdata, rid);
        end
        rst = 0;
        #1;
        total++;
        if (arready !== 1'b1 || arready_j !== 1'b1) begin
            bad++;
            $display("FAIL reset_release arready=%b arready_j=%b required 1", arready, arready_j);
        end
        for (int i = 0; i < DEPTH; i++) load(i, $urandom);
    endtask

    task automatic test_single();
        int lat;
        load(0, 32'h0000_0413);
        run_burst(32'h8000_0000, 0, 3'b010, 2'b00, 4'h5, 0, lat);
        total++;
        if (lat != 2) begin bad++; $display("FAIL single_latency got=%0d required=2", lat); end
    endtask

    task automatic test_incr();
        int lat;
        run_burst(32'h8000_0010, 3, 3'b010, 2'b01, 4'hA, 0, lat);
        total++;
        if (lat != 2) begin bad++; $display("FAIL incr_latency got=%0d required=2", lat); end
        run_burst(32'h8000_0040, 2, 3'b010, 2'b00, 4'h3, 0, lat);
        run_burst(32'h8000_0022, 1, 3'b010, 2'b01, 4'h7, 0, lat);
    endtask

    task automatic test_backpressure();
        int lat, h0;
        h0 = hs_cnt;
        run_burst(32'h8000_0010, 3, 3'b010, 2'b01, 4'hC, 1, lat);
        total++;
        if (hs_cnt - h0 != 4) begin bad++; $display("FAIL bp_handshakes got=%0d required=4", hs_cnt - h0); end
    endtask

    task automatic test_errors();
        int lat;
        run_burst(32'h8000_0FFC, 1, 3'b010, 2'b01, 4'h1, 0, lat);
        run_burst(32'h8000_0100, 2, 3'b001, 2'b01, 4'h2, 1, lat);
        run_burst(32'h8000_0100, 1, 3'b010, 2'b10, 4'h4, 0, lat);
        run_burst(32'h7FFF_FFF8, 3, 3'b010, 2'b01, 4'h6, 0, lat);
    endtask

    task automatic test_reset_mid();
        int lat, k;
        rready = 1; arvalid = 1; araddr = 32'h8000_0080; arlen = 7; arsize = 3'b010;
        arburst = 2'b01; arid = 4'h9;
        @(posedge clk); #1;
        arvalid = 0;
        k = 0;
        while (!rvalid && k < 20) begin @(posedge clk); #1; k++; end
        @(posedge clk); #1;
        total++;
        if (rvalid !== 1'b1 || rdata !== model_mem[33]) begin
            bad++;
            $display("FAIL mid_beat2 rvalid=%b rdata=%h required 1 %h", rvalid, rdata, model_mem[33]);
        end
        rst = 1;
        @(posedge clk); #1;
        total++;
        if (rvalid !== 1'b0 || arready !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset rvalid=%b arready=%b required 0 0", rvalid, arready);
        end
        rst = 0;
        @(posedge clk); #1;
        total++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            bad++;
            $display("FAIL mid_release rvalid=%b arready=%b required 0 1", rvalid, arready);
        end
        run_burst(32'h8000_0200, 2, 3'b010, 2'b01, 4'hE, 0, lat);
    endtask

    task automatic test_jitter();
        int lat;
        use_j = 1;
        for (int i = 0; i < 50; i++) begin
            if (i % 5 == 0) load(int'($urandom_range(0, DEPTH - 1)), $urandom);
            run_burst(BASE + 32'($urandom_range(0, 4 * DEPTH - 1)), 0, 3'b010, 2'($urandom_range(0, 1)),
                      4'($urandom), 0, lat);
            total++;
            if (lat < 2 || lat > 5) begin bad++; $display("FAIL jitter_latency got=%0d required 2..5", lat); end
        end
        use_j = 0;
    endtask

    task automatic test_random();
        int lat;
        for (int i = 0; i < 30; i++)
            run_burst(BASE + 32'($urandom_range(0, 4 * DEPTH - 1)), 8'($urandom_range(0, 7)),
                      ($urandom_range(0, 7) == 0) ? 3'b000 : 3'b010, 2'($urandom_range(0, 1)),
                      4'($urandom), 2, lat);
    endtask

    initial begin
        test_reset();
        test_single();
        test_incr();
        test_backpressure();
        test_errors();
        test_reset_mid();
        test_jitter();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
